// File: rtl/pll_rst_seq_pkg.sv
// Shared types and helpers for the PLL supervisor / domain reset sequencer.
//   state_t  : sequencer FSM states
//   CtrWidth : width needed to hold values 0..max
//   COUNT_W  : width of the saturating event counters
package pll_rst_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        SETTLE,
        RELEASE,
        RUN
    } state_t;

    localparam int COUNT_W = 8;

    function automatic int CtrWidth(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/pll_rst_sequencer_lock_sync.sv
// Two-flop synchronizer for the raw PLL LOCK signal.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops to 0
//   d   : asynchronous input
//   q   : synchronized output, two cycles of latency
module lock_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rst_sequencer.sv
// iCE40 PLL supervisor and staggered per-domain reset sequencer.
// Pulses PLL RESETB, waits for a synchronized and stable LOCK, then releases
// domain resets one at a time. Lock loss, lock timeout or restart re-run it.
//
// Ports:
//   clk             : free-running supervisor clock (independent of the PLL)
//   rst             : synchronous active-high reset
//   pll_lock        : raw PLL LOCK, asynchronous to clk
//   restart         : single-cycle request to re-run the full sequence
//   pll_resetb      : PLL RESETB, active-low
//   domain_rst      : per-domain resets, active-high, bit 0 released first
//   ready           : all domains released and lock good
//   retry_count     : saturating count of lock timeouts since rst
//   lock_loss_count : saturating count of RELEASE/RUN lock losses
//
// Build option: define PLL_RST_SEQUENCER_LOCK_LOSS_COUNT_EN to build the
// lock-loss counter; otherwise lock_loss_count is tied to 0.
module pll_rst_sequencer
    import pll_rst_seq_pkg::*;
#(
    parameter int DOMAINS             = 3,
    parameter int PLL_RESET_CYCLES    = 8,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int LOCK_WAIT_CYCLES    = 1024,
    parameter int STAGGER_CYCLES      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_resetb,
    output logic [DOMAINS-1:0] domain_rst,
    output logic               ready,
    output logic [COUNT_W-1:0] retry_count,
    output logic [COUNT_W-1:0] lock_loss_count
);

    // RELEASE counter value at which the last domain is released.
    localparam int REL_LAST = (DOMAINS - 1) * STAGGER_CYCLES;
    localparam int MAX_A    = (PLL_RESET_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                              PLL_RESET_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_B    = (LOCK_WAIT_CYCLES > REL_LAST + 1) ?
                              LOCK_WAIT_CYCLES : REL_LAST + 1;
    localparam int MAX_CNT  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW       = CtrWidth(MAX_CNT);

    typedef logic [CW-1:0] cnt_t;

    logic               lock_s;
    state_t             state, state_d;
    cnt_t               cnt, cnt_d;
    logic               retry_inc;
    logic [DOMAINS-1:0] domain_rst_d;

    lock_sync u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        retry_inc = 1'b0;
        if (restart) begin
            state_d = PLL_RST;
            cnt_d   = '0;
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == cnt_t'(PLL_RESET_CYCLES - 1)) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + cnt_t'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else if (cnt == cnt_t'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        state_d   = PLL_RST;
                        cnt_d     = '0;
                        retry_inc = 1'b1;
                    end else begin
                        cnt_d = cnt + cnt_t'(1);
                    end
                end
                SETTLE: begin
                    // A dropout here just means lock was not yet stable.
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt == cnt_t'(LOCK_WAIT_CYCLES - 1)) begin
                        state_d = RELEASE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + cnt_t'(1);
                    end
                end
                RELEASE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt == cnt_t'(REL_LAST)) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + cnt_t'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs are decoded from the next state so the registers line up
        // with the state they describe (no extra cycle of lag).
        for (int k = 0; k < DOMAINS; k++) begin
            domain_rst_d[k] = !((state_d == RUN) ||
                                ((state_d == RELEASE) &&
                                 (cnt_d >= cnt_t'(k * STAGGER_CYCLES))));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PLL_RST;
            cnt         <= '0;
            pll_resetb  <= 1'b0;
            domain_rst  <= '1;
            ready       <= 1'b0;
            retry_count <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            pll_resetb <= (state_d != PLL_RST);
            domain_rst <= domain_rst_d;
            ready      <= (state_d == RUN);
            if (retry_inc && (retry_count != '1))
                retry_count <= retry_count + COUNT_W'(1);
        end
    end

`ifdef PLL_RST_SEQUENCER_LOCK_LOSS_COUNT_EN
    // restart outranks lock loss, so a same-cycle restart is not counted.
    logic loss_evt;
    assign loss_evt = !restart && !lock_s && ((state == RELEASE) || (state == RUN));

    always_ff @(posedge clk) begin
        if (rst)
            lock_loss_count <= '0;
        else if (loss_evt && (lock_loss_count != '1))
            lock_loss_count <= lock_loss_count + COUNT_W'(1);
    end
`else
    assign lock_loss_count = '0;
`endif

endmodule
